// File: rtl/step_ctrl_pkg.sv
// step_ctrl shared types: FSM state encodings and run-mode constants.
// Also used by the display/LED logic.
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    RUN  = 2'd2,
    BRK  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_STEP = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_RUNN = 2'b10;
  localparam logic [1:0] MODE_BP   = 2'b11;

endpackage

// File: rtl/step_ctrl_rise.sv
// rise_det: rising-edge detector on a level already synchronous to clk.
// The output is combinational: d high now, low on the previous clock.
module rise_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  // Remember last cycle's level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) d_q <= 1'b0;
    else         d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/step_ctrl.sv
// step_ctrl: CPU execution sequencer (step / free-run / run-N / run-to-bp).
// Breakpoint logic (mode 11, BRK state) exists only with STEP_CTRL_BP_EN.
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int CNT_W   = 16,
  parameter int RUN_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_req,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] n_steps,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_ce,
  output logic             busy,
  output logic             bp_hit,
  output logic [CNT_W-1:0] step_count,
  output logic [1:0]       state
);

  localparam int DW = $clog2(RUN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);

  logic step_rise;
  logic run_rise;
  logic halt_rise;

  rise_det u_step (.clk_i(clk), .rst_ni(rst), .d_i(step_req), .rise_o(step_rise));
  rise_det u_run  (.clk_i(clk), .rst_ni(rst), .d_i(run_req),  .rise_o(run_rise));
  rise_det u_halt (.clk_i(clk), .rst_ni(rst), .d_i(halt_req), .rise_o(halt_rise));

  state_e          state_q;
  logic            cpu_ce_q;
  logic            busy_q;
  logic            bp_hit_q;
  logic [DW-1:0]   div_q;
  logic [CNT_W-1:0] remain_q;
  logic [1:0]      mode_q;
  logic            first_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic            bp_stop;

`ifdef STEP_CTRL_BP_EN
  logic [PC_W-1:0] bp_q;

  // Latch the breakpoint address when a run starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    bp_q <= '0;
    else if (run_rise && state_q inside {IDLE, BRK}) bp_q <= bp_addr;
  end

  // First slot after entry always issues so a run can leave the bp.
  assign bp_stop = (mode_q == MODE_BP) && !first_q && (pc == bp_q);
  assign bp_hit  = bp_hit_q;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_addr, pc, first_q, bp_hit_q};
  assign bp_stop   = 1'b0;
  assign bp_hit    = 1'b0;
`endif

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cpu_ce_q <= 1'b0;
      busy_q   <= 1'b0;
      bp_hit_q <= 1'b0;
      div_q    <= '0;
      remain_q <= '0;
      mode_q   <= MODE_STEP;
      first_q  <= 1'b0;
    end else begin
      cpu_ce_q <= 1'b0;
      unique case (state_q)
        IDLE, BRK: begin
          if (run_rise) begin
            bp_hit_q <= 1'b0;
            mode_q   <= mode;
            remain_q <= n_steps;
            div_q    <= '0;
            first_q  <= 1'b1;
            if (mode == MODE_STEP) begin
              state_q  <= STEP;
              cpu_ce_q <= 1'b1;
            end else if (mode == MODE_RUNN && n_steps == '0) begin
              state_q <= IDLE;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end else if (step_rise) begin
            bp_hit_q <= 1'b0;
            state_q  <= STEP;
            cpu_ce_q <= 1'b1;
          end else if (halt_rise && state_q == BRK) begin
            bp_hit_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        STEP: state_q <= IDLE;
        RUN: begin
          div_q <= (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
          if (halt_rise || run_rise) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (div_q == DIV_LAST) begin
            first_q <= 1'b0;
            if (bp_stop) begin
              state_q  <= BRK;
              busy_q   <= 1'b0;
              bp_hit_q <= 1'b1;
            end else begin
              cpu_ce_q <= 1'b1;
              if (mode_q == MODE_RUNN) begin
                remain_q <= remain_q - CNT_W'(1);
                if (remain_q == CNT_W'(1)) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                end
              end
            end
          end
        end
      endcase
    end
  end

  assign cnt_d = cnt_q + CNT_W'(cpu_ce_q);

  // Count issued pulses; wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cpu_ce     = cpu_ce_q;
  assign busy       = busy_q;
  assign step_count = cnt_q;
  assign state      = state_q;

endmodule

// File: tb/tb_step_ctrl.sv
// tb_step_ctrl: directed tests for step_ctrl (CNT_W=4, RUN_DIV=4).
// Breakpoint expectations follow STEP_CTRL_BP_EN.
module tb_step_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step_req = 1'b0;
  logic        run_req = 1'b0;
  logic        halt_req = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [3:0]  n_steps = 4'd0;
  logic [31:0] bp_addr = 32'd0;
  logic [31:0] pc = 32'd0;
  logic        cpu_ce;
  logic        busy;
  logic        bp_hit;
  logic [3:0]  step_count;
  logic [1:0]  state;

  int total = 0;
  int bad = 0;
  logic [3:0]  exp_cnt = 4'd0;
  logic [31:0] m;

  always #5 clk = ~clk;

  step_ctrl #(.PC_W(32), .CNT_W(4), .RUN_DIV(4)) dut (
    .clk(clk), .rst(rst),
    .step_req(step_req), .run_req(run_req), .halt_req(halt_req),
    .mode(mode), .n_steps(n_steps), .bp_addr(bp_addr), .pc(pc),
    .cpu_ce(cpu_ce), .busy(busy), .bp_hit(bp_hit),
    .step_count(step_count), .state(state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_run();
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
  endtask

  // Clocks n cycles; bit i of mask = pulse seen i cycles after entry.
  task automatic run_window(input int n, input int halt_at,
                            output logic [31:0] mask);
    mask = '0;
    for (int i = 1; i <= n; i++) begin
      halt_req = (i == halt_at);
      tick();
      if (cpu_ce === 1'b1) begin
        mask[i] = 1'b1;
        pc = pc + 32'd4;
      end
    end
    halt_req = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++; if (cpu_ce !== 1'b0) begin bad++; $display("FAIL rst_ce: got %0h want 0", cpu_ce); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0h want 0", busy); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL rst_state: got %0h want 0", state); end
    total++; if (step_count !== 4'd0) begin bad++; $display("FAIL rst_cnt: got %0h want 0", step_count); end
    total++; if (bp_hit !== 1'b0) begin bad++; $display("FAIL rst_bphit: got %0h want 0", bp_hit); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_step();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    total++; if (cpu_ce !== 1'b1) begin bad++; $display("FAIL step_ce: got %0h want 1", cpu_ce); end
    total++; if (state !== 2'd1) begin bad++; $display("FAIL step_state: got %0h want 1", state); end
    tick();
    exp_cnt = exp_cnt + 4'd1;
    total++; if (cpu_ce !== 1'b0) begin bad++; $display("FAIL step_ce_off: got %0h want 0", cpu_ce); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL step_idle: got %0h want 0", state); end
    total++; if (step_count !== exp_cnt) begin bad++; $display("FAIL step_cnt: got %0h want %0h", step_count, exp_cnt); end
  endtask

  task automatic test_run_n();
    mode = 2'b10;
    n_steps = 4'd3;
    press_run();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL runn_busy: got %0h want 1", busy); end
    total++; if (state !== 2'd2) begin bad++; $display("FAIL runn_state: got %0h want 2", state); end
    run_window(16, -1, m);
    exp_cnt = exp_cnt + 4'd3;
    total++; if (m !== 32'h0000_1110) begin bad++; $display("FAIL runn_pulses: got %0h want 1110", m); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL runn_idle: got %0h want 0", state); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL runn_busy_off: got %0h want 0", busy); end
    total++; if (step_count !== exp_cnt) begin bad++; $display("FAIL runn_cnt: got %0h want %0h", step_count, exp_cnt); end
  endtask

  task automatic test_free_halt();
    mode = 2'b01;
    press_run();
    run_window(16, 12, m);
    exp_cnt = exp_cnt + 4'd2;
    total++; if (m !== 32'h0000_0110) begin bad++; $display("FAIL halt_pulses: got %0h want 110", m); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL halt_idle: got %0h want 0", state); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL halt_busy: got %0h want 0", busy); end
    total++; if (step_count !== exp_cnt) begin bad++; $display("FAIL halt_cnt: got %0h want %0h", step_count, exp_cnt); end
  endtask

  task automatic test_mode0_run();
    mode = 2'b00;
    press_run();
    total++; if (cpu_ce !== 1'b1) begin bad++; $display("FAIL m0_ce: got %0h want 1", cpu_ce); end
    total++; if (state !== 2'd1) begin bad++; $display("FAIL m0_state: got %0h want 1", state); end
    tick();
    exp_cnt = exp_cnt + 4'd1;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL m0_idle: got %0h want 0", state); end
    total++; if (step_count !== exp_cnt) begin bad++; $display("FAIL m0_cnt: got %0h want %0h", step_count, exp_cnt); end
  endtask

  task automatic test_priority();
    mode = 2'b01;
    step_req = 1'b1;
    run_req = 1'b1;
    tick();
    step_req = 1'b0;
    run_req = 1'b0;
    total++; if (state !== 2'd2) begin bad++; $display("FAIL prio_state: got %0h want 2", state); end
    total++; if (cpu_ce !== 1'b0) begin bad++; $display("FAIL prio_ce: got %0h want 0", cpu_ce); end
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    total++; if (state !== 2'd2) begin bad++; $display("FAIL run_ign_step: got %0h want 2", state); end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL prio_halt: got %0h want 0", state); end
    total++; if (step_count !== exp_cnt) begin bad++; $display("FAIL prio_cnt: got %0h want %0h", step_count, exp_cnt); end
  endtask

  task automatic test_breakpoint();
    pc = 32'd0;
    mode = 2'b11;
    bp_addr = 32'h0000_000C;
    press_run();
    run_window(16, -1, m);
`ifdef STEP_CTRL_BP_EN
    exp_cnt = exp_cnt + 4'd3;
    total++; if (m !== 32'h0000_1110) begin bad++; $display("FAIL bp_pulses: got %0h want 1110", m); end
    total++; if (state !== 2'd3) begin bad++; $display("FAIL bp_state: got %0h want 3", state); end
    total++; if (bp_hit !== 1'b1) begin bad++; $display("FAIL bp_hit: got %0h want 1", bp_hit); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_busy: got %0h want 0", busy); end
    total++; if (pc !== 32'h0000_000C) begin bad++; $display("FAIL bp_pc: got %0h want c", pc); end
    press_run();
    total++; if (bp_hit !== 1'b0) begin bad++; $display("FAIL bp_clear: got %0h want 0", bp_hit); end
    total++; if (state !== 2'd2) begin bad++; $display("FAIL bp_rerun: got %0h want 2", state); end
    run_window(6, 6, m);
    exp_cnt = exp_cnt + 4'd1;
    total++; if (m !== 32'h0000_0010) begin bad++; $display("FAIL bp_leave: got %0h want 10", m); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL bp_idle: got %0h want 0", state); end
`else
    exp_cnt = exp_cnt + 4'd4;
    total++; if (m !== 32'h0001_1110) begin bad++; $display("FAIL nobp_pulses: got %0h want 11110", m); end
    total++; if (state !== 2'd2) begin bad++; $display("FAIL nobp_state: got %0h want 2", state); end
    total++; if (bp_hit !== 1'b0) begin bad++; $display("FAIL nobp_hit: got %0h want 0", bp_hit); end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL nobp_halt: got %0h want 0", state); end
`endif
    total++; if (step_count !== exp_cnt) begin bad++; $display("FAIL bp_cnt: got %0h want %0h", step_count, exp_cnt); end
  endtask

  task automatic test_async_reset();
    mode = 2'b01;
    press_run();
    run_window(6, -1, m);
    exp_cnt = exp_cnt + 4'd1;
    total++; if (m !== 32'h0000_0010) begin bad++; $display("FAIL ar_pulse: got %0h want 10", m); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ar_busy_pre: got %0h want 1", busy); end
    total++; if (step_count !== exp_cnt) begin bad++; $display("FAIL ar_cnt_pre: got %0h want %0h", step_count, exp_cnt); end
    #2 rst = 1'b0;
    #1;
    total++; if (cpu_ce !== 1'b0) begin bad++; $display("FAIL ar_ce: got %0h want 0", cpu_ce); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_busy: got %0h want 0", busy); end
    total++; if (step_count !== 4'd0) begin bad++; $display("FAIL ar_cnt: got %0h want 0", step_count); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL ar_state: got %0h want 0", state); end
    #2 rst = 1'b1;
    exp_cnt = 4'd0;
    run_window(12, -1, m);
    total++; if (m !== 32'h0) begin bad++; $display("FAIL ar_quiet: got %0h want 0", m); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL ar_idle: got %0h want 0", state); end
  endtask

  task automatic test_wrap();
    int seen;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      if (cpu_ce === 1'b1) seen++;
      tick();
    end
    total++; if (seen !== 15) begin bad++; $display("FAIL wrap_seen: got %0d want 15", seen); end
    total++; if (step_count !== 4'd15) begin bad++; $display("FAIL wrap_15: got %0h want f", step_count); end
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick();
    total++; if (step_count !== 4'd0) begin bad++; $display("FAIL wrap_0: got %0h want 0", step_count); end
    mode = 2'b10;
    n_steps = 4'd0;
    press_run();
    total++; if (state !== 2'd0) begin bad++; $display("FAIL n0_state: got %0h want 0", state); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL n0_busy: got %0h want 0", busy); end
    run_window(8, -1, m);
    total++; if (m !== 32'h0) begin bad++; $display("FAIL n0_pulses: got %0h want 0", m); end
    total++; if (step_count !== 4'd0) begin bad++; $display("FAIL n0_cnt: got %0h want 0", step_count); end
  endtask

  initial begin
    test_reset();
    test_step();
    test_run_n();
    test_free_halt();
    test_mode0_run();
    test_priority();
    test_breakpoint();
    test_async_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
